// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch squash, operand forwarding, mul/div occupancy.
// Optional stall counter enabled by defining HAZ_STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LAT = 4
`ifdef HAZ_STALL_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_md,
  input  logic       id_jmp,
  input  logic       e_wreg,
  input  logic       e_m2reg,
  input  logic [4:0] e_rn,
  input  logic       m_wreg,
  input  logic       m_m2reg,
  input  logic [4:0] m_rn,
  output logic       wpcir,
  output logic       bubble,
  output logic       flush_if,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       md_busy
`ifdef HAZ_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned MD_CNT_W = 4;
  localparam logic [MD_CNT_W-1:0] MD_CNT_INIT = MD_CNT_W'(MD_LAT - 2);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MD  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic                load_use;

  // Load in EX whose destination is read by the ID instruction.
  always_comb begin : load_use_detect
    load_use = e_wreg && e_m2reg && (e_rn != 5'd0) &&
               ((id_use_rs && (id_rs == e_rn)) || (id_use_rt && (id_rt == e_rn)));
  end

  always_comb begin : hazard_fsm
    state_d  = state_q;
    cnt_d    = cnt_q;
    wpcir    = 1'b1;
    bubble   = 1'b0;
    flush_if = 1'b0;
    md_busy  = 1'b0;
    if (!clr) begin
      case (state_q)
        ST_RUN: begin
          if (load_use) begin
            wpcir  = 1'b0;
            bubble = 1'b1;
          end else begin
            flush_if = id_jmp;
            if (id_md) begin
              state_d = ST_MD;
              cnt_d   = MD_CNT_INIT;
            end
          end
        end
        ST_MD: begin
          wpcir   = 1'b0;
          bubble  = 1'b1;
          md_busy = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - MD_CNT_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // EX ALU result beats MEM; a load still in EX is never a forwarding source.
  always_comb begin : fwd_select
    fwda = 2'b00;
    fwdb = 2'b00;
    if (!clr) begin
      if (e_wreg && !e_m2reg && (e_rn != 5'd0) && (e_rn == id_rs)) begin
        fwda = 2'b01;
      end else if (m_wreg && (m_rn != 5'd0) && (m_rn == id_rs)) begin
        fwda = m_m2reg ? 2'b11 : 2'b10;
      end
      if (e_wreg && !e_m2reg && (e_rn != 5'd0) && (e_rn == id_rt)) begin
        fwdb = 2'b01;
      end else if (m_wreg && (m_rn != 5'd0) && (m_rn == id_rt)) begin
        fwdb = m_m2reg ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (clr) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles in which the front end was held.
  always_comb begin : stall_cnt_next
    stall_cnt_d = stall_cnt_q;
    if (!wpcir && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin : stall_cnt_reg
    if (clr) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MD_LAT=4); stall counter checks under HAZ_STALL_CNT_EN.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       clr;
  logic [4:0] id_rs, id_rt;
  logic       id_use_rs, id_use_rt, id_md, id_jmp;
  logic       e_wreg, e_m2reg;
  logic [4:0] e_rn;
  logic       m_wreg, m_m2reg;
  logic [4:0] m_rn;
  logic       wpcir, bubble, flush_if, md_busy;
  logic [1:0] fwda, fwdb;
`ifdef HAZ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int ncmp = 0;
  int nerr = 0;

  pipe_hazard_ctrl #(.MD_LAT(4)) dut (
    .clk(clk), .clr(clr),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md(id_md), .id_jmp(id_jmp),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn),
    .wpcir(wpcir), .bubble(bubble), .flush_if(flush_if),
    .fwda(fwda), .fwdb(fwdb), .md_busy(md_busy)
`ifdef HAZ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic idle();
    clr = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_md = 1'b0; id_jmp = 1'b0; e_wreg = 1'b0; e_m2reg = 1'b0; e_rn = 5'd0;
    m_wreg = 1'b0; m_m2reg = 1'b0; m_rn = 5'd0;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    next_cycle();
    clr = 1'b1; e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd2; id_use_rs = 1'b1; id_rs = 5'd2;
    id_jmp = 1'b1; m_wreg = 1'b1; m_rn = 5'd2;
    #1;
    ncmp++; if (wpcir !== 1'b1) begin nerr++; $display("FAIL rst_wpcir got %b exp 1", wpcir); end
    ncmp++; if (bubble !== 1'b0) begin nerr++; $display("FAIL rst_bubble got %b exp 0", bubble); end
    ncmp++; if (flush_if !== 1'b0) begin nerr++; $display("FAIL rst_flush got %b exp 0", flush_if); end
    ncmp++; if (fwda !== 2'b00) begin nerr++; $display("FAIL rst_fwda got %b exp 00", fwda); end
    ncmp++; if (md_busy !== 1'b0) begin nerr++; $display("FAIL rst_md_busy got %b exp 0", md_busy); end
    next_cycle();
    #1;
    ncmp++; if (wpcir !== 1'b1 || md_busy !== 1'b0) begin nerr++; $display("FAIL post_rst got wpcir=%b md_busy=%b exp 1/0", wpcir, md_busy); end
`ifdef HAZ_STALL_CNT_EN
    ncmp++; if (stall_cnt !== 16'd0) begin nerr++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
`endif
  endtask

  task automatic test_load_use();
    next_cycle();
    e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd2; id_use_rs = 1'b1; id_rs = 5'd2;
    #1;
    ncmp++; if (wpcir !== 1'b0 || bubble !== 1'b1) begin nerr++; $display("FAIL lu_stall got wpcir=%b bubble=%b exp 0/1", wpcir, bubble); end
    next_cycle();
    id_use_rs = 1'b1; id_rs = 5'd2; m_wreg = 1'b1; m_m2reg = 1'b1; m_rn = 5'd2;
    #1;
    ncmp++; if (fwda !== 2'b11) begin nerr++; $display("FAIL lu_fwda got %b exp 11", fwda); end
    ncmp++; if (wpcir !== 1'b1 || bubble !== 1'b0) begin nerr++; $display("FAIL lu_release got wpcir=%b bubble=%b exp 1/0", wpcir, bubble); end
    next_cycle();
    e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd7; id_use_rt = 1'b1; id_rt = 5'd7;
    #1;
    ncmp++; if (wpcir !== 1'b0) begin nerr++; $display("FAIL lu_rt_stall got wpcir=%b exp 0", wpcir); end
    id_use_rt = 1'b0;
    #1;
    ncmp++; if (wpcir !== 1'b1 || bubble !== 1'b0) begin nerr++; $display("FAIL lu_rt_unused got wpcir=%b bubble=%b exp 1/0", wpcir, bubble); end
  endtask

  task automatic test_reg0();
    next_cycle();
    e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd0; id_use_rs = 1'b1; id_rs = 5'd0;
    m_wreg = 1'b1; m_rn = 5'd0;
    #1;
    ncmp++; if (wpcir !== 1'b1 || bubble !== 1'b0) begin nerr++; $display("FAIL r0_nostall got wpcir=%b bubble=%b exp 1/0", wpcir, bubble); end
    ncmp++; if (fwda !== 2'b00) begin nerr++; $display("FAIL r0_fwda got %b exp 00", fwda); end
  endtask

  task automatic test_fwd_priority();
    next_cycle();
    e_wreg = 1'b1; e_rn = 5'd5; m_wreg = 1'b1; m_rn = 5'd5;
    id_use_rt = 1'b1; id_rt = 5'd5; id_use_rs = 1'b1; id_rs = 5'd9;
    #1;
    ncmp++; if (fwdb !== 2'b01) begin nerr++; $display("FAIL fwd_ex got %b exp 01", fwdb); end
    ncmp++; if (fwda !== 2'b00) begin nerr++; $display("FAIL fwd_nomatch got %b exp 00", fwda); end
    e_wreg = 1'b0;
    #1;
    ncmp++; if (fwdb !== 2'b10) begin nerr++; $display("FAIL fwd_mem_alu got %b exp 10", fwdb); end
    m_m2reg = 1'b1; id_rs = 5'd5;
    #1;
    ncmp++; if (fwdb !== 2'b11 || fwda !== 2'b11) begin nerr++; $display("FAIL fwd_mem_load got a=%b b=%b exp 11/11", fwda, fwdb); end
  endtask

  task automatic test_md();
    next_cycle();
    clr = 1'b1;
    next_cycle();
    id_md = 1'b1;
    #1;
    ncmp++; if (wpcir !== 1'b1 || md_busy !== 1'b0) begin nerr++; $display("FAIL md_issue got wpcir=%b md_busy=%b exp 1/0", wpcir, md_busy); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      id_jmp = (i == 1);
      #1;
      ncmp++; if (md_busy !== 1'b1 || wpcir !== 1'b0 || bubble !== 1'b1 || flush_if !== 1'b0) begin
        nerr++; $display("FAIL md_busy_c%0d got busy=%b wpcir=%b bubble=%b flush=%b exp 1/0/1/0", i, md_busy, wpcir, bubble, flush_if);
      end
    end
    next_cycle();
    #1;
    ncmp++; if (md_busy !== 1'b0 || wpcir !== 1'b1 || bubble !== 1'b0) begin nerr++; $display("FAIL md_done got busy=%b wpcir=%b bubble=%b exp 0/1/0", md_busy, wpcir, bubble); end
`ifdef HAZ_STALL_CNT_EN
    ncmp++; if (stall_cnt !== 16'd3) begin nerr++; $display("FAIL md_stall_cnt got %0d exp 3", stall_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    next_cycle();
    id_md = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      id_md = 1'b1;
      #1;
      ncmp++; if (md_busy !== 1'b1 || wpcir !== 1'b0) begin nerr++; $display("FAIL b2b_wait_c%0d got busy=%b wpcir=%b exp 1/0", i, md_busy, wpcir); end
    end
    next_cycle();
    id_md = 1'b1;
    #1;
    ncmp++; if (md_busy !== 1'b0 || wpcir !== 1'b1) begin nerr++; $display("FAIL b2b_issue got busy=%b wpcir=%b exp 0/1", md_busy, wpcir); end
    next_cycle();
    #1;
    ncmp++; if (md_busy !== 1'b1) begin nerr++; $display("FAIL b2b_reenter got busy=%b exp 1", md_busy); end
    for (int i = 0; i < 2; i++) next_cycle();
    next_cycle();
    #1;
    ncmp++; if (md_busy !== 1'b0) begin nerr++; $display("FAIL b2b_exit got busy=%b exp 0", md_busy); end
  endtask

  task automatic test_jmp_stall();
    next_cycle();
    e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd3; id_use_rt = 1'b1; id_rt = 5'd3; id_jmp = 1'b1;
    #1;
    ncmp++; if (flush_if !== 1'b0 || wpcir !== 1'b0) begin nerr++; $display("FAIL jmp_stall got flush=%b wpcir=%b exp 0/0", flush_if, wpcir); end
    next_cycle();
    id_use_rt = 1'b1; id_rt = 5'd3; id_jmp = 1'b1;
    #1;
    ncmp++; if (flush_if !== 1'b1 || wpcir !== 1'b1 || bubble !== 1'b0) begin nerr++; $display("FAIL jmp_flush got flush=%b wpcir=%b bubble=%b exp 1/1/0", flush_if, wpcir, bubble); end
  endtask

  task automatic test_reset_md();
    next_cycle();
    id_md = 1'b1;
    next_cycle();
    #1;
    ncmp++; if (md_busy !== 1'b1) begin nerr++; $display("FAIL rmd_enter got busy=%b exp 1", md_busy); end
    next_cycle();
    clr = 1'b1;
    #1;
    ncmp++; if (wpcir !== 1'b1 || md_busy !== 1'b0 || bubble !== 1'b0) begin nerr++; $display("FAIL rmd_clr got wpcir=%b busy=%b bubble=%b exp 1/0/0", wpcir, md_busy, bubble); end
    next_cycle();
    #1;
    ncmp++; if (wpcir !== 1'b1 || md_busy !== 1'b0) begin nerr++; $display("FAIL rmd_run got wpcir=%b busy=%b exp 1/0", wpcir, md_busy); end
`ifdef HAZ_STALL_CNT_EN
    ncmp++; if (stall_cnt !== 16'd0) begin nerr++; $display("FAIL rmd_stall_cnt got %0d exp 0", stall_cnt); end
`endif
  endtask

  initial begin
    idle();
    clr = 1'b1;
    test_reset();
    test_load_use();
    test_reg0();
    test_fwd_priority();
    test_md();
    test_back_to_back();
    test_jmp_stall();
    test_reset_md();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
